// File: rtl/serial_deserializer_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_deserializer_if
//  Description : Valid/ready output channel of the serial deserializer. The
//                data bits drive the D inputs of the downstream falling-edge
//                capture register bank.
//  Signals     : out_data  [WIDTH] assembled word, LSB received first
//                out_valid         word available in the holding register
//                out_ready         consumer accepts the word on this edge
//  Modports    : master - producer (deserializer) side
//                slave  - consumer side
//  Revision    : 1.0 - initial release
// ============================================================================
interface serial_deserializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface : serial_deserializer_if
`default_nettype wire

// File: rtl/serial_deserializer.sv
`default_nettype none
// ============================================================================
//  Module      : serial_deserializer
//  Description : Assembles a start/stop-framed serial bit stream, sampled on
//                a one-cycle bit strobe, into a WIDTH-bit parallel word and
//                presents it on a valid/ready handshake. Framing errors and
//                overruns are reported as single-cycle pulses.
//  Ports       : clk        single clock, all state updates on rising edge
//                reset      asynchronous active-low reset
//                sin        serial data, sampled only while sin_en=1
//                sin_en     bit strobe, one cycle per serial bit
//                bus        master side of the output handshake
//                           (out_data / out_valid / out_ready)
//                frame_err  one-cycle pulse: stop bit sampled low
//                overrun    one-cycle pulse: completed word dropped because
//                           the holding register was still occupied
//                busy       high while a frame is in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_deserializer #(
    parameter int WIDTH = 8
) (
    input  wire logic                    clk,
    input  wire logic                    reset,
    input  wire logic                    sin,
    input  wire logic                    sin_en,
    serial_deserializer_if.master        bus,
    output logic                         frame_err,
    output logic                         overrun,
    output logic                         busy
);

    localparam int             CW     = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  c_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_STOP = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_bit_cnt;

    // The holding register can take a new word when it is empty or when the
    // consumer is draining it on this very edge (seamless replacement).
    logic w_hold_free;
    assign w_hold_free = !bus.out_valid || bus.out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_shift       <= '0;
            r_bit_cnt     <= '0;
            bus.out_data  <= '0;
            bus.out_valid <= 1'b0;
            frame_err     <= 1'b0;
            overrun       <= 1'b0;
            busy          <= 1'b0;
        end else begin
            // Status flags are pulses: cleared every edge unless set below.
            frame_err <= 1'b0;
            overrun   <= 1'b0;

            // Handshake runs independently of the bit strobe. A load in the
            // STOP branch below overrides this clear.
            if (bus.out_valid && bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end

            if (sin_en) begin
                case (r_state)
                    S_IDLE: begin
                        if (!sin) begin
                            r_state   <= S_DATA;
                            r_bit_cnt <= '0;
                            busy      <= 1'b1;
                        end
                    end

                    S_DATA: begin
                        // Shift right with the new bit at the MSB so the first
                        // received bit ends up in bit 0.
                        r_shift   <= {sin, r_shift[WIDTH-1:1]};
                        r_bit_cnt <= r_bit_cnt + CW'(1);
                        if (r_bit_cnt == c_LAST) begin
                            r_state <= S_STOP;
                        end
                    end

                    S_STOP: begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                        if (!sin) begin
                            frame_err <= 1'b1;
                        end else if (w_hold_free) begin
                            bus.out_data  <= r_shift;
                            bus.out_valid <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end

                    default: begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule : serial_deserializer
`default_nettype wire
